// File: rtl/rr_arbiter_router.sv
// Round-robin ingress-to-egress router: pops one word from a non-empty ingress FIFO and pushes it to the egress FIFO named by its dest field.
// Latency: pop 1 cycle after selection, push 2 cycles after pop; at most one word per 2 cycles.
// Backpressure: new selections are held off while any egress almost_full is set; an in-flight transfer always completes.
module rr_arbiter_router #(
    parameter int WORD_SIZE = 6,
    parameter int NUM_PORTS = 4
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic [NUM_PORTS-1:0]           fifo_empty_in,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] fifo_data_in,
    input  logic [NUM_PORTS-1:0]           almost_full_out,
    input  logic                           enable,
    output logic [NUM_PORTS-1:0]           pop,
    output logic [NUM_PORTS-1:0]           push,
    output logic [WORD_SIZE-1:0]           data_out,
    output logic [1:0]                     grant,
    output logic                           idle
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             rr_ptr;
    logic [NUM_PORTS-1:0]   req;
    logic                   go;
    logic [1:0]             scan_base;
    logic [1:0]             scan_idx;
    logic [1:0]             sel;
    logic [WORD_SIZE-1:0]   cap_word;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] idx);
        onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign req = ~fifo_empty_in;
    assign go  = enable & ~|almost_full_out & |req;

    // In CAPTURE rr_ptr is being updated on the same edge, so scan from grant+1 directly.
    always_comb begin
        scan_base = (state == CAPTURE) ? grant + 2'd1 : rr_ptr;
        scan_idx  = '0;
        sel       = scan_base;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            scan_idx = scan_base + 2'(k);
            if (req[scan_idx]) begin
                sel = scan_idx;
            end
        end
    end

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == 2'(i)) begin
                cap_word = fifo_data_in[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            pop      <= '0;
            push     <= '0;
            data_out <= '0;
            grant    <= 2'd0;
            idle     <= 1'b1;
        end else begin
            push <= '0;
            case (state)
                IDLE: begin
                    if (go) begin
                        grant <= sel;
                        pop   <= onehot(sel);
                        idle  <= 1'b0;
                        state <= POP;
                    end else begin
                        pop   <= '0;
                        idle  <= 1'b1;
                    end
                end
                POP: begin
                    pop   <= '0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    data_out <= cap_word;
                    push     <= onehot(cap_word[WORD_SIZE-1:WORD_SIZE-2]);
                    rr_ptr   <= grant + 2'd1;
                    if (go) begin
                        grant <= sel;
                        pop   <= onehot(sel);
                        state <= POP;
                    end else begin
                        pop   <= '0;
                        idle  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    pop   <= '0;
                    idle  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_router.sv
// Bench for rr_arbiter_router: ingress FIFOs emulated with queues, outputs checked every cycle against a transaction-level model.
module tb_rr_arbiter_router;

    localparam int W = 6;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset_L;
    logic [N-1:0]     fifo_empty_in;
    logic [N*W-1:0]   fifo_data_in;
    logic [N-1:0]     almost_full_out;
    logic             enable;
    logic [N-1:0]     pop;
    logic [N-1:0]     push;
    logic [W-1:0]     data_out;
    logic [1:0]       grant;
    logic             idle;

    always #5 clk = ~clk;

    rr_arbiter_router #(.WORD_SIZE(W), .NUM_PORTS(N)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .fifo_empty_in   (fifo_empty_in),
        .fifo_data_in    (fifo_data_in),
        .almost_full_out (almost_full_out),
        .enable          (enable),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .grant           (grant),
        .idle            (idle)
    );

    int tests = 0;
    int fails = 0;
    string phase = "init";
    bit emu_on = 1'b0;

    // Ingress FIFO emulation: queue contents plus registered output word.
    logic [W-1:0] q [N][$];
    logic [W-1:0] dreg [N];

    // Reference model state: edges since last selection, round-robin pointer, expected outputs.
    int           m_cnt;
    int           m_ptr;
    logic [N-1:0] e_pop;
    logic [N-1:0] e_push;
    logic [W-1:0] e_data;
    logic [W-1:0] pend;
    logic [1:0]   e_grant;
    logic         e_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        if (emu_on) begin
            for (int i = 0; i < N; i++) begin
                fifo_empty_in[i]          = (q[i].size() == 0);
                fifo_data_in[i*W +: W]    = dreg[i];
            end
        end
    endtask

    task automatic model_reset();
        m_cnt   = 3;
        m_ptr   = 0;
        e_pop   = '0;
        e_push  = '0;
        e_data  = '0;
        e_grant = 2'd0;
        e_idle  = 1'b1;
        pend    = '0;
    endtask

    task automatic check_outputs();
        check({phase, ":pop"},   32'(pop),      32'(e_pop));
        check({phase, ":push"},  32'(push),     32'(e_push));
        check({phase, ":data"},  32'(data_out), 32'(e_data));
        check({phase, ":grant"}, 32'(grant),    32'(e_grant));
        check({phase, ":idle"},  32'(idle),     32'(e_idle));
    endtask

    task automatic tick();
        logic         rst_pre;
        logic         en_pre;
        logic [N-1:0] af_pre;
        logic [N-1:0] req_pre;
        logic [N-1:0] pop_pre;
        int           c;
        int           sel;
        rst_pre = reset_L;
        en_pre  = enable;
        af_pre  = almost_full_out;
        req_pre = ~fifo_empty_in;
        pop_pre = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_pre[i] && q[i].size() > 0) dreg[i] = q[i].pop_front();
        end
        drive_fifos();
        if (!rst_pre || !reset_L) begin
            model_reset();
        end else begin
            c      = (m_cnt >= 3) ? 3 : m_cnt + 1;
            e_pop  = '0;
            e_push = '0;
            // The word selected two edges ago lands in the egress FIFO now.
            if (c == 2) begin
                e_push = 4'b0001 << pend[W-1:W-2];
                e_data = pend;
            end
            if (c >= 2 && en_pre && af_pre == '0 && req_pre != '0) begin
                sel = -1;
                for (int k = 0; k < N; k++) begin
                    automatic int p = (m_ptr + k) % N;
                    if (sel < 0 && req_pre[p]) sel = p;
                end
                e_pop   = 4'b0001 << sel;
                e_grant = 2'(sel);
                pend    = (q[sel].size() > 0) ? q[sel][0] : '0;
                m_ptr   = (sel + 1) % N;
                m_cnt   = 0;
            end else begin
                m_cnt = c;
            end
            e_idle = (m_cnt >= 2);
        end
        check_outputs();
    endtask

    task automatic wait_pop(input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            n++;
            if (pop != '0) break;
        end
        check({phase, ":pop_timeout"}, 32'(pop != '0), 32'd1);
    endtask

    initial begin
        int n;
        reset_L         = 1'b0;
        enable          = 1'b0;
        almost_full_out = '0;
        fifo_empty_in   = '1;
        fifo_data_in    = '0;
        for (int i = 0; i < N; i++) dreg[i] = '0;
        model_reset();

        phase = "reset";
        repeat (8) begin
            fifo_empty_in   = 4'($urandom);
            fifo_data_in    = 24'($urandom);
            almost_full_out = 4'($urandom);
            enable          = 1'($urandom);
            tick();
        end
        enable          = 1'b0;
        almost_full_out = '0;
        emu_on          = 1'b1;
        drive_fifos();
        reset_L = 1'b1;
        tick();
        tick();

        phase = "rr";
        for (int i = 0; i < N; i++) begin
            q[i].push_back(6'($urandom));
            q[i].push_back(6'($urandom));
        end
        drive_fifos();
        enable = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_pop(10, n);
            check("rr:grant_order", 32'(grant), 32'(g % 4));
            if (g > 0) begin
                check("rr:pop_spacing", 32'(n), 32'd2);
                check("rr:push_overlap", 32'(|push), 32'd1);
            end
        end
        repeat (20) tick();

        phase = "single";
        q[2].push_back(6'b01_1010);
        drive_fifos();
        wait_pop(10, n);
        check("single:pop", 32'(pop), 32'b0100);
        tick();
        check("single:pop_one_cycle", 32'(pop), 32'd0);
        tick();
        check("single:push", 32'(push), 32'b0010);
        check("single:data", 32'(data_out), 32'h1a);
        tick();
        check("single:push_one_cycle", 32'(push), 32'd0);
        check("single:data_hold", 32'(data_out), 32'h1a);

        phase = "stall";
        almost_full_out = 4'b1000;
        q[0].push_back(6'($urandom));
        drive_fifos();
        repeat (5) begin
            tick();
            check("stall:no_pop", 32'(pop), 32'd0);
        end
        almost_full_out = '0;
        tick();
        check("stall:resume_pop", 32'(pop), 32'b0001);
        repeat (3) tick();

        phase = "stall_mid";
        q[1].push_back(6'($urandom));
        q[1].push_back(6'($urandom));
        drive_fifos();
        wait_pop(10, n);
        almost_full_out = 4'b0100;
        tick();
        tick();
        check("stall_mid:push_done", 32'(|push), 32'd1);
        repeat (4) begin
            tick();
            check("stall_mid:no_pop", 32'(pop), 32'd0);
        end
        almost_full_out = '0;
        tick();
        check("stall_mid:resume_pop", 32'(pop), 32'b0010);
        repeat (3) tick();

        phase = "random";
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) begin
                automatic int p = int'($urandom_range(0, N - 1));
                if (q[p].size() < 4) q[p].push_back(6'($urandom));
            end
            enable          = ($urandom_range(0, 7) != 0);
            almost_full_out = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            drive_fifos();
            tick();
        end
        almost_full_out = '0;
        enable          = 1'b1;
        repeat (30) tick();

        phase = "arst";
        q[0].push_back(6'($urandom));
        q[0].push_back(6'($urandom));
        for (int i = 1; i < N; i++) q[i].push_back(6'($urandom));
        drive_fifos();
        wait_pop(10, n);
        tick();
        reset_L = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (3) begin
            tick();
            check("arst:no_push", 32'(push), 32'd0);
        end
        reset_L = 1'b1;
        wait_pop(10, n);
        check("arst:restart_port0", 32'(pop), 32'b0001);
        check("arst:restart_grant", 32'(grant), 32'd0);
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
